// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// The font is active-low {dp,g,f,e,d,c,b,a} with dp dark in every entry.
package seg7_pkg;

    typedef logic [3:0] nibble_t;

    localparam int unsigned DIGITS_MAX = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [7:0] SEG7_FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,  // 0 1 2 3
        8'h99, 8'h92, 8'h82, 8'hF8,  // 4 5 6 7
        8'h80, 8'h90, 8'h88, 8'h83,  // 8 9 A b
        8'hC6, 8'hA1, 8'h86, 8'h8E   // C d E F
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Producer-side bus of the scan controller: display data, per-digit dp and
// blank bits, the load strobe and the live brightness setting.
interface seg7_scan_ctrl_if #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PWM_BITS = 4
);

    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic [PWM_BITS-1:0] brightness;

    modport master (
        output data_in,
        output dp_in,
        output blank_in,
        output load,
        output brightness
    );

    modport slave (
        input data_in,
        input dp_in,
        input blank_in,
        input load,
        input brightness
    );

endinterface

// File: rtl/seg7_font_dec.sv
// Combinational hex-nibble to active-low segment decoder with decimal point.
module seg7_font_dec
    import seg7_pkg::*;
(
    input  nibble_t    nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Look up the glyph, then light the dp segment (bit 7) if requested.
    always_comb begin
        seg = SEG7_FONT[nibble];
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with double-buffered
// loads applied at frame boundaries, per-digit blank/dp and PWM brightness.
// Optional build macro SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    seg7_scan_ctrl_if.slave   bus,
    output logic [DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]        HEX_OUT,
    output logic              frame_done
);

    import seg7_pkg::*;

    localparam int unsigned TICK = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int unsigned TW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

    if (TICK == 0 || (TICK % (2 ** PWM_BITS)) != 0) begin : g_tick_chk
        $fatal(1, "seg7_scan_ctrl: TICK=%0d is not a multiple of 2**PWM_BITS", TICK);
    end

    if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_digits_chk
        $fatal(1, "seg7_scan_ctrl: DIGITS=%0d out of range 1..%0d", DIGITS, DIGITS_MAX);
    end

    logic [TW-1:0]       slot_cnt;
    logic [IW-1:0]       digit_idx;
    logic                slot_last;
    logic                boundary;

    logic [4*DIGITS-1:0] pend_data, act_data;
    logic [DIGITS-1:0]   pend_dp, act_dp;
    logic [DIGITS-1:0]   pend_blank, act_blank;
    logic                upd;

    nibble_t             act_nib [DIGITS];
    logic [DIGITS-1:0]   lzb_mask;
    logic [PWM_BITS-1:0] phase;
    logic                digit_en;
    logic [7:0]          cur_seg;
    logic [DIGITS-1:0]   sel_d;
    logic [7:0]          hex_d;

    assign slot_last = (slot_cnt == TICK_LAST);
    assign boundary  = slot_last && (digit_idx == DIGIT_LAST);

    // Slot counter runs 0..TICK-1; digit index steps on each slot wrap.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // Pending/active banks: loads park in pending and are promoted only at the
    // frame boundary; a load on the boundary itself goes straight to active.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            upd        <= 1'b0;
        end else if (boundary) begin
            upd <= 1'b0;
            if (bus.load) begin
                act_data  <= bus.data_in;
                act_dp    <= bus.dp_in;
                act_blank <= bus.blank_in;
            end else if (upd) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
        end else if (bus.load) begin
            pend_data  <= bus.data_in;
            pend_dp    <= bus.dp_in;
            pend_blank <= bus.blank_in;
            upd        <= 1'b1;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign act_nib[g] = act_data[4*g +: 4];
    end

`ifdef SEG7_LZB_EN
    logic lzb_run;

    // Blank zero digits from the top down until a nonzero nibble or a lit dp.
    always_comb begin
        lzb_mask = '0;
        lzb_run  = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (act_nib[i] != 4'h0 || act_dp[i]) begin
                lzb_run = 1'b0;
            end
            lzb_mask[i] = lzb_run;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    assign phase    = slot_cnt[TW-1 -: PWM_BITS];
    assign digit_en = (phase <= bus.brightness) && !act_blank[digit_idx]
                      && !lzb_mask[digit_idx];

    seg7_font_dec u_font_dec (
        .nibble (act_nib[digit_idx]),
        .dp     (act_dp[digit_idx]),
        .seg    (cur_seg)
    );

    // Next pin values: one select low and the glyph when lit, else all dark.
    always_comb begin
        sel_d = '1;
        hex_d = SEG_OFF;
        if (digit_en) begin
            sel_d[digit_idx] = 1'b0;
            hex_d            = cur_seg;
        end
    end

    // Registered pins; frame_done lines up with the last slot's outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            SEG_SELECT_OUT <= '1;
            HEX_OUT        <= SEG_OFF;
            frame_done     <= 1'b0;
        end else begin
            SEG_SELECT_OUT <= sel_d;
            HEX_OUT        <= hex_d;
            frame_done     <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: DIGITS=4, TICK=16, one cycle per PWM
// phase. Each frame's expected pins are pushed as the frame is driven and
// compared on the falling edge. Compile with SEG7_LZB_EN for the LZB build.
module tb_seg7_scan_ctrl;

    localparam int unsigned DIGITS = 4;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] hex;
        logic       fd;
        logic [7:0] frm;
        logic [7:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sel_out;
    logic [7:0] hex_out;
    logic       fd_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   frm_no   = 0;
    exp_t exp_q [$];
    exp_t e;

    logic [7:0] font [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

`ifdef SEG7_LZB_EN
    localparam logic [3:0] DARK_5     = 4'b1110;
    localparam logic [3:0] DARK_5_B0  = 4'b1111;
    localparam logic [3:0] DARK_5_DP2 = 4'b1000;
`else
    localparam logic [3:0] DARK_5     = 4'b0000;
    localparam logic [3:0] DARK_5_B0  = 4'b0001;
    localparam logic [3:0] DARK_5_DP2 = 4'b0000;
`endif

    seg7_scan_ctrl_if #(.DIGITS(DIGITS), .PWM_BITS(4)) bus ();

    seg7_scan_ctrl #(
        .DIGITS   (DIGITS),
        .CLK_HZ   (64000),
        .SCAN_HZ  (1000),
        .PWM_BITS (4)
    ) dut (
        .clk_sys        (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .SEG_SELECT_OUT (sel_out),
        .HEX_OUT        (hex_out),
        .frame_done     (fd_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one expected pin set per output cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val($sformatf("f%0d c%0d sel", e.frm, e.cyc), 32'(sel_out), 32'(e.sel));
            check_val($sformatf("f%0d c%0d hex", e.frm, e.cyc), 32'(hex_out), 32'(e.hex));
            check_val($sformatf("f%0d c%0d frame_done", e.frm, e.cyc), 32'(fd_out), 32'(e.fd));
        end
    end

    // Run one 64-cycle frame expecting show_* on the pins, with up to two
    // loads driven at the given frame-local cycles (-1 = none).
    task automatic run_frame(input logic [15:0] show_data, input logic [3:0] show_dp,
                             input logic [3:0] dark, input int ld_at,
                             input logic [15:0] ld_data, input logic [3:0] ld_dp,
                             input logic [3:0] ld_blank, input int ld2_at,
                             input logic [15:0] ld2_data);
        exp_t       x;
        int         d;
        int         ph;
        logic [3:0] nib;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            d   = i / 16;
            ph  = i % 16;
            nib = show_data[4*d +: 4];
            x.frm = 8'(frm_no);
            x.cyc = 8'(i);
            x.fd  = (i == 63);
            if (ph <= int'(bus.brightness) && !dark[d]) begin
                x.sel    = 4'hF;
                x.sel[d] = 1'b0;
                x.hex    = font[nib];
                if (show_dp[d]) x.hex[7] = 1'b0;
            end else begin
                x.sel = 4'hF;
                x.hex = 8'hFF;
            end
            exp_q.push_back(x);
            bus.load = 1'b0;
            if (i == ld_at || i == ld2_at) begin
                bus.data_in  = (i == ld2_at) ? ld2_data : ld_data;
                bus.dp_in    = ld_dp;
                bus.blank_in = ld_blank;
                bus.load     = 1'b1;
            end
        end
        frm_no++;
    endtask

    initial begin
        bus.data_in    = '0;
        bus.dp_in      = '0;
        bus.blank_in   = '0;
        bus.load       = 1'b0;
        bus.brightness = 4'd15;

        repeat (3) @(posedge clk);
        #2;
        check_val("reset sel", 32'(sel_out), 32'hF);
        check_val("reset hex", 32'(hex_out), 32'hFF);
        check_val("reset frame_done", 32'(fd_out), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        run_frame(16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        run_frame(16'h0000, 4'h0, 4'h0, 20, 16'h1A2F, 4'h0, 4'h0, -1, 16'h0);
        run_frame(16'h1A2F, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        bus.brightness = 4'd3;
        run_frame(16'h1A2F, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        bus.brightness = 4'd15;
        run_frame(16'h1A2F, 4'h0, 4'h0, 5, 16'h1111, 4'h0, 4'h0, 40, 16'h2222);
        run_frame(16'h2222, 4'h0, 4'h0, 62, 16'h3333, 4'h0, 4'h0, -1, 16'h0);
        run_frame(16'h3333, 4'h0, 4'h0, 30, 16'h0005, 4'h0, 4'h0, -1, 16'h0);
        run_frame(16'h0005, 4'h0, DARK_5, 30, 16'h0005, 4'h0, 4'b0001, -1, 16'h0);
        run_frame(16'h0005, 4'h0, DARK_5_B0, 30, 16'h0005, 4'b0100, 4'h0, -1, 16'h0);
        run_frame(16'h0005, 4'b0100, DARK_5_DP2, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        // Park a pending load, then reset mid-frame between clock edges.
        bus.data_in  = 16'h7777;
        bus.dp_in    = 4'hF;
        bus.blank_in = 4'h0;
        bus.load     = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (36) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async reset sel", 32'(sel_out), 32'hF);
        check_val("async reset hex", 32'(hex_out), 32'hFF);
        check_val("async reset frame_done", 32'(fd_out), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame(16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        run_frame(16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        @(negedge clk);
        #1;
        check_val("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
